// File: rtl/sram_serial_host_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_serial_host_if
// Brief    : Request/response bus plus serial SRAM load/unload port bundle
//            for sram_serial_host. The slave modport is the host block's view
//            and the master modport is the requester/device view.
// Revision : 1.0  initial release
// ============================================================================
interface sram_serial_host_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  // parallel request / response side
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  // serial SRAM port side
  logic                  CTRL_BGN;
  logic [1:0]            CTRL_MODE;
  logic                  LOAD_N;
  logic                  CTRL_SI;
  logic                  CTRL_SO;
  logic                  CTRL_RDY;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, CTRL_SO, CTRL_RDY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           CTRL_BGN, CTRL_MODE, LOAD_N, CTRL_SI
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, CTRL_SO, CTRL_RDY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           CTRL_BGN, CTRL_MODE, LOAD_N, CTRL_SI
  );
endinterface
`default_nettype wire

// File: rtl/sram_serial_host.sv
`default_nettype none
// ============================================================================
// Module   : sram_serial_host
// Brief    : Host-side master for the serial SRAM load/unload port. Turns a
//            single-word write/read request into a {addr,data} serial frame,
//            commits it, waits for CTRL_RDY and, for reads, shifts the frame
//            back out to recover the data byte.
//            Optional macro SRAM_HOST_VERIFY_EN: every successful write is
//            followed by an automatic readback of the same address and the
//            response flags an error if the byte read back differs.
// Revision : 1.0  initial release
// ============================================================================
module sram_serial_host #(
  parameter int ADDR_WIDTH  = 9,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int RDY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  sram_serial_host_if.slave bus
);

  localparam int BIT_W = $clog2(FRAME_WIDTH);
  localparam int TO_W  = $clog2(RDY_TIMEOUT + 1);

  localparam logic [1:0] c_mode_idle = 2'b00;
  localparam logic [1:0] c_mode_wr   = 2'b01;
  localparam logic [1:0] c_mode_rd   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SHIFT  = 3'd2,
    S_COMMIT = 3'd3,
    S_WAIT   = 3'd4,
    S_UNLOAD = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_WIDTH-1:0] shreg_q, shreg_d;
  logic                   we_q,    we_d;
  logic [BIT_W-1:0]       bit_q,   bit_d;
  logic [TO_W-1:0]        to_q,    to_d;
  logic [DATA_WIDTH-1:0]  cap_q,   cap_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q,   err_d;
`ifdef SRAM_HOST_VERIFY_EN
  logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   vfy_q,   vfy_d;
`endif

  logic last_bit;
  logic bgn;

  assign last_bit = (bit_q == BIT_W'(FRAME_WIDTH - 1));
  // the serial port owns the SRAM from the start cycle through the last unload bit
  assign bgn      = (state_q == S_START)  || (state_q == S_SHIFT) ||
                    (state_q == S_COMMIT) || (state_q == S_WAIT)  ||
                    (state_q == S_UNLOAD);

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.CTRL_BGN  = bgn;
  assign bus.CTRL_MODE = bgn ? (we_q ? c_mode_wr : c_mode_rd) : c_mode_idle;
  assign bus.LOAD_N    = !((state_q == S_SHIFT) || (state_q == S_UNLOAD));
  assign bus.CTRL_SI   = (state_q == S_SHIFT) ? shreg_q[FRAME_WIDTH-1] : 1'b0;

  // state and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      we_q    <= 1'b0;
      bit_q   <= '0;
      to_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef SRAM_HOST_VERIFY_EN
      addr_q  <= '0;
      wdata_q <= '0;
      vfy_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      we_q    <= we_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef SRAM_HOST_VERIFY_EN
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      vfy_q   <= vfy_d;
`endif
    end
  end

  // next-state and datapath update for the frame sequencer
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    we_d    = we_q;
    bit_d   = bit_q;
    to_d    = to_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef SRAM_HOST_VERIFY_EN
    addr_d  = addr_q;
    wdata_d = wdata_q;
    vfy_d   = vfy_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          // read frames carry an all-zero data field
          shreg_d = {bus.req_addr, (bus.req_we ? bus.req_wdata : {DATA_WIDTH{1'b0}})};
          we_d    = bus.req_we;
          err_d   = 1'b0;
          state_d = S_START;
`ifdef SRAM_HOST_VERIFY_EN
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          vfy_d   = 1'b0;
`endif
        end
      end

      S_START: begin
        bit_d   = '0;
        to_d    = '0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        shreg_d = {shreg_q[FRAME_WIDTH-2:0], 1'b0};
        if (last_bit) begin
          state_d = S_COMMIT;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end

      S_COMMIT: begin
        // to_q counts cycles elapsed since the commit cycle
        to_d    = TO_W'(1);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (bus.CTRL_RDY) begin
          if (we_q) begin
`ifdef SRAM_HOST_VERIFY_EN
            // chain straight into a readback of the same word
            shreg_d = {addr_q, {DATA_WIDTH{1'b0}}};
            we_d    = 1'b0;
            vfy_d   = 1'b1;
            state_d = S_START;
`else
            state_d = S_DONE;
`endif
          end else begin
            bit_d   = '0;
            state_d = S_UNLOAD;
          end
        end else if (to_q == TO_W'(RDY_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end

      S_UNLOAD: begin
        // address bits fall off the top; the last DATA_WIDTH bits remain
        cap_d = {cap_q[DATA_WIDTH-2:0], bus.CTRL_SO};
        if (last_bit) begin
          rdata_d = cap_d;
`ifdef SRAM_HOST_VERIFY_EN
          if (vfy_q && (cap_d != wdata_q)) begin
            err_d = 1'b1;
          end
`endif
          state_d = S_DONE;
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_serial_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_serial_host
// Brief    : Self-checking bench for sram_serial_host with a reactive serial
//            SRAM device model and a latency/data reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_serial_host;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int FW = AW + DW;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_serial_host_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_serial_host #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FRAME_WIDTH(FW),
    .RDY_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- device model ----------------
  int            dev_delay   = 0;
  logic [DW-1:0] dev_corrupt = '0;
  logic [DW-1:0] dev_mem [0:(1<<AW)-1];
  logic [FW-1:0] dev_in, dev_out, last_frame;
  logic [1:0]    last_mode;
  int            dev_phase = 0, dev_nbits = 0, last_nbits = 0, dev_wcnt = 0, dev_idx = 0;

  initial begin
    bus.CTRL_SO  = 1'b0;
    bus.CTRL_RDY = 1'b0;
    for (int i = 0; i < (1<<AW); i++) dev_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!bus.CTRL_BGN) begin
        dev_phase    = 0;
        bus.CTRL_RDY = 1'b0;
        bus.CTRL_SO  = 1'b0;
      end else begin
        case (dev_phase)
          0: if (!bus.LOAD_N) begin
               dev_in    = {{(FW-1){1'b0}}, bus.CTRL_SI};
               dev_nbits = 1;
               dev_phase = 1;
             end
          1: if (!bus.LOAD_N) begin
               dev_in = {dev_in[FW-2:0], bus.CTRL_SI};
               dev_nbits++;
             end else begin
               last_frame = dev_in;
               last_nbits = dev_nbits;
               last_mode  = bus.CTRL_MODE;
               if (bus.CTRL_MODE == 2'b01) dev_mem[dev_in[FW-1:DW]] = dev_in[DW-1:0];
               else dev_out = {dev_in[FW-1:DW], dev_mem[dev_in[FW-1:DW]] ^ dev_corrupt};
               dev_wcnt  = 0;
               dev_phase = 2;
             end
          2: begin
               if (dev_wcnt == dev_delay) begin
                 bus.CTRL_RDY = 1'b1;
                 dev_phase    = 3;
               end
               dev_wcnt++;
             end
          3: begin
               bus.CTRL_RDY = 1'b0;
               if (!bus.LOAD_N) begin
                 bus.CTRL_SO = dev_out[FW-1];
                 dev_idx     = 1;
                 dev_phase   = 4;
               end else begin
                 dev_phase = 0;
               end
             end
          4: if (!bus.LOAD_N && dev_idx < FW) begin
               bus.CTRL_SO = dev_out[FW-1-dev_idx];
               dev_idx++;
             end
          default: dev_phase = 0;
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic bit timed_out(input int d);
    return d > TO - 2;
  endfunction

  // cycles from the accept cycle to the rsp_valid cycle
  function automatic int exp_latency(input logic we, input int d);
    if (timed_out(d)) return 19 + TO;   // commit cycle 19, then TO cycles
    if (!we) return 38 + d;
`ifdef SRAM_HOST_VERIFY_EN
    return (20 + d) + (38 + d);
`else
    return 21 + d;
`endif
  endfunction

  function automatic logic [FW-1:0] exp_frame(input logic we, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d);
`ifdef SRAM_HOST_VERIFY_EN
    if (we) return {a, {DW{1'b0}}};
`endif
    return we ? {a, d} : {a, {DW{1'b0}}};
  endfunction

  function automatic logic [1:0] exp_mode(input logic we);
`ifdef SRAM_HOST_VERIFY_EN
    return 2'b10;
`else
    return we ? 2'b01 : 2'b10;
`endif
  endfunction

  function automatic bit exp_err(input logic we, input int d);
`ifdef SRAM_HOST_VERIFY_EN
    if (we && dev_corrupt != '0) return 1'b1;
`endif
    return timed_out(d);
  endfunction

  task automatic wait_rsp(output int rsp, output bit ok);
    ok  = 1'b0;
    rsp = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.rsp_valid) begin
        ok  = 1'b1;
        rsp = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_rsp(input string tag, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int delay, input int acc,
                           input int rsp);
    check({tag, "/lat"}, rsp - acc, exp_latency(we, delay));
    check({tag, "/err"}, bus.rsp_err, exp_err(we, delay));
    check({tag, "/bgn_done"}, bus.CTRL_BGN, 1'b0);
    if (!timed_out(delay)) begin
      check({tag, "/frame"}, last_frame, exp_frame(we, addr, wdata));
      check({tag, "/mode"}, last_mode, exp_mode(we));
      check({tag, "/nbits"}, last_nbits, FW);
      if (!we) check({tag, "/rdata"}, bus.rsp_rdata, ref_mem[addr] ^ dev_corrupt);
`ifdef SRAM_HOST_VERIFY_EN
      if (we) check({tag, "/vrdata"}, bus.rsp_rdata, wdata ^ dev_corrupt);
`endif
    end
    if (we) ref_mem[addr] = wdata;
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int delay);
    int acc, rsp;
    bit ok;
    dev_delay = delay;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    check({tag, "/ready"}, bus.req_ready, 1'b1);
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, "/busy"}, bus.req_ready, 1'b0);
    check({tag, "/bgn"}, bus.CTRL_BGN, 1'b1);
    wait_rsp(rsp, ok);
    check({tag, "/rsp_seen"}, ok, 1'b1);
    if (ok) check_rsp(tag, we, addr, wdata, delay, acc, rsp);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc1, acc2, r1, r2, hits;
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst/ready", bus.req_ready, 1'b1);
    check("rst/rsp_valid", bus.rsp_valid, 1'b0);
    check("rst/rdata", bus.rsp_rdata, 8'h00);
    check("rst/err", bus.rsp_err, 1'b0);
    check("rst/bgn", bus.CTRL_BGN, 1'b0);
    check("rst/mode", bus.CTRL_MODE, 2'b00);
    check("rst/load_n", bus.LOAD_N, 1'b1);
    check("rst/si", bus.CTRL_SI, 1'b0);
    rst = 1'b0;

    // directed cases
    run_txn("wr010", 1'b1, 9'h010, 8'hA5, 0);
    run_txn("wr1ff", 1'b1, 9'h1FF, 8'h3C, 2);
    run_txn("rd1ff", 1'b0, 9'h1FF, 8'h00, 0);
    run_txn("rd010", 1'b0, 9'h010, 8'h00, 5);
    run_txn("tmo_rd", 1'b0, 9'h010, 8'h00, 1000);
    run_txn("tmo_wr", 1'b1, 9'h033, 8'hC3, 1000);
    run_txn("after_tmo", 1'b1, 9'h034, 8'h7E, 3);
    run_txn("edge62", 1'b0, 9'h034, 8'h00, TO - 2);
    run_txn("edge63", 1'b0, 9'h034, 8'h00, TO - 1);

    // reset in the middle of shifting bit 8
    dev_delay = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 9'h0AA; bus.req_wdata = 8'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rstmid/in_shift", bus.LOAD_N, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid/bgn", bus.CTRL_BGN, 1'b0);
    check("rstmid/load_n", bus.LOAD_N, 1'b1);
    check("rstmid/ready", bus.req_ready, 1'b1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.rsp_valid) hits++;
      @(negedge clk);
    end
    check("rstmid/no_rsp", hits, 0);

    // back-to-back writes with req_valid held
    dev_delay = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 9'h000; bus.req_wdata = 8'h11;
    acc1 = cyc;
    @(negedge clk);
    bus.req_addr = 9'h001; bus.req_wdata = 8'h22;
    wait_rsp(r1, ok);
    check("b2b/rsp1_seen", ok, 1'b1);
    if (ok) begin
      check_rsp("b2b1", 1'b1, 9'h000, 8'h11, 0, acc1, r1);
      @(negedge clk);
      check("b2b/ready2", bus.req_ready, 1'b1);
      acc2 = cyc;
      check("b2b/gap", acc2 - r1, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      wait_rsp(r2, ok);
      check("b2b/rsp2_seen", ok, 1'b1);
      if (ok) check_rsp("b2b2", 1'b1, 9'h001, 8'h22, 0, acc2, r2);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;

`ifdef SRAM_HOST_VERIFY_EN
    // readback returns a corrupted byte
    dev_corrupt = 8'h01;
    run_txn("vfy_bad", 1'b1, 9'h020, 8'h5A, 0);
    check("vfy_bad/single", bus.rsp_valid, 1'b0);
    dev_corrupt = 8'h00;
    run_txn("vfy_ok", 1'b1, 9'h021, 8'h96, 1);
`endif

    // randomized traffic over a small address window so reads hit written words
    for (int n = 0; n < 24; n++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            dl;
      w  = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 15));
      d  = DW'($urandom_range(0, 255));
      dl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 4));
      run_txn("rnd", w, a, d, dl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_serial_host.md
Name: sram_serial_host

Overview:
- Host-side master for the serial SRAM load/unload port (CTRL_BGN / CTRL_MODE / LOAD_N / CTRL_SI / CTRL_SO / CTRL_RDY) of the 8-bit SCPU test top.
- Accepts parallel single-word write/read requests, serializes each into a 17-bit address+data frame, commits it, waits for RDY, and for reads shifts the frame back out and returns the data byte.
- Used in tester/FPGA wrappers to preload program memory and dump results.

Parameters:
- ADDR_WIDTH, 9, SRAM address bits.
- DATA_WIDTH, 8, SRAM data bits.
- FRAME_WIDTH, ADDR_WIDTH+DATA_WIDTH (17), serial frame length.
- RDY_TIMEOUT, 64, max cycles to wait for CTRL_RDY before flagging error.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  host accepts request this cycle (high only in IDLE).
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle pulse: operation finished.
- rsp_rdata  out  DATA_WIDTH  read data (held until next rsp_valid).
- rsp_err  out  1  valid with rsp_valid; 1 = RDY timeout (or verify mismatch).
- CTRL_BGN  out  1  serial port owns SRAM while high.
- CTRL_MODE  out  2  01=write, 10=read, 00=idle.
- LOAD_N  out  1  low = shift phase, high = commit/hold.
- CTRL_SI  out  1  serial data to device, MSB first.
- CTRL_SO  in  1  serial data from device, MSB first.
- CTRL_RDY  in  1  device finished commit.

Behaviour:
- Reset (RST=1 at edge): state IDLE. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, CTRL_BGN=0, CTRL_MODE=00, LOAD_N=1, CTRL_SI=0. Bit counter and timeout counter cleared. Reset mid-operation aborts immediately; no rsp_valid is issued.
- Frame = {addr[8:0], data[7:0]}, MSB (addr[8]) first; read frames carry data=0.
- IDLE: on req_valid & req_ready, latch frame and we into the shift register. Next cycle: CTRL_BGN=1, CTRL_MODE=01/10, go to SHIFT.
- SHIFT: LOAD_N=0, CTRL_SI=shreg[16], shift left each cycle. Exactly 17 cycles, then COMMIT.
- COMMIT: LOAD_N=1 for exactly 1 cycle, CTRL_SI=0, then WAIT_RDY.
- WAIT_RDY: count cycles.
  - CTRL_RDY=1: writes go to DONE; reads go to UNLOAD.
  - Counter reaches RDY_TIMEOUT without RDY: DONE with err=1.
  - RDY already high on the first WAIT_RDY cycle is accepted (zero-wait).
- UNLOAD (read only): LOAD_N=0, CTRL_MODE=10, sample CTRL_SO on each of 17 edges into the capture register, MSB first. rsp_rdata = captured bits [7:0]. Address bits are discarded.
- DONE: single cycle; rsp_valid=1, CTRL_BGN=0, CTRL_MODE=00, LOAD_N=1; return to IDLE.
- req_ready is low from acceptance through DONE; req_valid during that time is ignored and not queued.
- Latency, write with zero-wait RDY: accept → rsp_valid = 1+17+1+1+1 = 21 cycles. A zero-wait read adds 17 cycles (38 cycles).
- Back-to-back requests: next accept is possible in the cycle after DONE. CTRL_BGN drops for at least 1 cycle between operations.

Optional Feature:
- Macro SRAM_HOST_VERIFY_EN.
- Defined: after a successful write, the block automatically performs a read of the same address, without returning to IDLE and without a rsp_valid between the two operations.
  - rsp_valid is asserted once, at the end of the readback.
  - rsp_rdata = readback byte; rsp_err=1 if it differs from the written byte or either RDY wait timed out.
  - Zero-wait write latency becomes 21+38-1 = 58 cycles.
- Undefined: writes finish after WAIT_RDY as described; no readback logic is synthesized.

Test Plan:
- Write addr=0x010, data=0xA5, CTRL_RDY tied high → CTRL_SI sequence 0_0001_0000_1010_0101 over 17 LOAD_N-low cycles; rsp_valid at cycle 21; rsp_err=0.
- Read addr=0x1FF; device model drives CTRL_SO = frame 0x1FF_3C after RDY → rsp_rdata=0x3C, rsp_err=0, rsp_valid at cycle 38.
- CTRL_RDY held low → rsp_valid with rsp_err=1 exactly RDY_TIMEOUT(64) cycles after COMMIT; next request still accepted.
- RST pulsed during SHIFT bit 8 → next cycle CTRL_BGN=0, LOAD_N=1, req_ready=1, no rsp_valid.
- Two back-to-back writes (0x000←0x11, 0x001←0x22) with req_valid held → second accepted 1 cycle after first rsp_valid; CTRL_BGN low ≥1 cycle between operations.
- With SRAM_HOST_VERIFY_EN, write 0x020←0x5A; device returns 0x5B on readback → single rsp_valid, rsp_rdata=0x5B, rsp_err=1.
